// File: rtl/route_query_sched_pkg.sv
// Shared constants and types for the route-query scheduler in front of the
// single shortest-path engine.
package route_pkg;

    localparam int unsigned NODE_W = 5;
    localparam int unsigned DIST_W = 32;
    localparam logic [DIST_W-1:0] INF = 32'd9999999;

    typedef enum logic [2:0] {
        IDLE,
        CFG,
        START,
        BUSY,
        RESP
    } state_t;

    typedef struct packed {
        logic [NODE_W-1:0] src;
        logic [NODE_W-1:0] dest;
    } query_t;

endpackage

// File: rtl/route_query_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr, with
// wrap, wins; grant is one-hot plus its index.
module rr_arbiter #(
    parameter  int unsigned NREQ  = 4,
    localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    int unsigned      cand;
    logic [IDX_W-1:0] ci;

    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = 0;
        ci   = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = (32'(ptr) + i) % NREQ;
            ci   = IDX_W'(cand);
            if (!any && req[ci]) begin
                any     = 1'b1;
                gnt[ci] = 1'b1;
                idx     = ci;
            end
        end
    end

endmodule

// File: rtl/route_query_sched.sv
// Round-robin query scheduler driving one shortest-path engine through a
// start/done handshake, with idle-only gating of graph-configuration writes.
module route_query_sched
    import route_pkg::*;
#(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*NODE_W-1:0] req_src,
    input  logic [NREQ*NODE_W-1:0] req_dest,
    output logic [NREQ-1:0]        req_ready,
    output logic [NREQ-1:0]        resp_valid,
    output logic [DIST_W-1:0]      resp_dist,
    output logic                   resp_err,
    output logic                   eng_start,
    output logic                   eng_abort,
    output logic [NODE_W-1:0]      eng_src,
    output logic [NODE_W-1:0]      eng_dest,
    input  logic                   eng_done,
    input  logic [DIST_W-1:0]      eng_dist,
    input  logic                   cfg_req,
    output logic                   cfg_grant
);

    localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CNT_W = $clog2(TIMEOUT);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q;
    logic [IDX_W-1:0]   gidx_q;
    query_t             query_q;
    query_t             sel_q;
    logic [DIST_W-1:0]  dist_q;
    logic               err_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               timeout_hit;

    logic [NREQ-1:0]    arb_gnt;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_any;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req (req_valid),
        .ptr (ptr_q),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    always_comb begin
        sel_q.src  = req_src[arb_idx*NODE_W +: NODE_W];
        sel_q.dest = req_dest[arb_idx*NODE_W +: NODE_W];
    end

    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));
    assign eng_src     = query_q.src;
    assign eng_dest    = query_q.dest;

    // Outputs are held low while reset is asserted so a reset landing on the
    // timeout cycle cannot leak an abort or response pulse.
    always_comb begin
        state_d    = state_q;
        req_ready  = '0;
        resp_valid = '0;
        resp_dist  = '0;
        resp_err   = 1'b0;
        eng_start  = 1'b0;
        eng_abort  = 1'b0;
        cfg_grant  = 1'b0;
        if (!reset) begin
            case (state_q)
                IDLE: begin
                    if (cfg_req) begin
                        state_d = CFG;
                    end else if (arb_any) begin
                        req_ready = arb_gnt;
                        state_d   = (sel_q.src == sel_q.dest) ? RESP : START;
                    end
                end
                CFG: begin
                    cfg_grant = 1'b1;
                    if (!cfg_req) state_d = IDLE;
                end
                START: begin
                    eng_start = 1'b1;
                    state_d   = BUSY;
                end
                BUSY: begin
                    if (eng_done) begin
                        state_d = RESP;
                    end else if (timeout_hit) begin
                        eng_abort = 1'b1;
                        state_d   = RESP;
                    end
                end
                RESP: begin
                    resp_valid[gidx_q] = 1'b1;
                    resp_dist          = dist_q;
                    resp_err           = err_q;
                    state_d            = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gidx_q  <= '0;
            query_q <= '0;
            dist_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (!cfg_req && arb_any) begin
                        gidx_q  <= arb_idx;
                        query_q <= sel_q;
                        dist_q  <= '0;
                        err_q   <= 1'b0;
                    end
                end
                START: cnt_q <= '0;
                BUSY: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (eng_done) begin
                        dist_q <= eng_dist;
                        err_q  <= (eng_dist >= INF);
                    end else if (timeout_hit) begin
                        dist_q <= INF;
                        err_q  <= 1'b1;
                    end
                end
                RESP: ptr_q <= (gidx_q == IDX_W'(NREQ - 1)) ? '0 : gidx_q + 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_route_query_sched.sv
// Directed plus randomized bench for route_query_sched, checked against a
// transaction-level reference model of arbitration and engine outcomes.
module tb_route_query_sched;

    localparam int          TIMEOUT = 16;
    localparam logic [31:0] INF     = 32'd9999999;

    logic        clk;
    logic        reset;
    logic [3:0]  req_valid;
    logic [19:0] req_src;
    logic [19:0] req_dest;
    logic [3:0]  req_ready;
    logic [3:0]  resp_valid;
    logic [31:0] resp_dist;
    logic        resp_err;
    logic        eng_start;
    logic        eng_abort;
    logic [4:0]  eng_src;
    logic [4:0]  eng_dest;
    logic        eng_done;
    logic [31:0] eng_dist;
    logic        cfg_req;
    logic        cfg_grant;

    int n_vec = 0;
    int n_err = 0;
    int exp_ptr = 0;

    route_query_sched #(.NREQ(4), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_src    (req_src),
        .req_dest   (req_dest),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_dist  (resp_dist),
        .resp_err   (resp_err),
        .eng_start  (eng_start),
        .eng_abort  (eng_abort),
        .eng_src    (eng_src),
        .eng_dest   (eng_dest),
        .eng_done   (eng_done),
        .eng_dist   (eng_dist),
        .cfg_req    (cfg_req),
        .cfg_grant  (cfg_grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [3:0] onehot(input int w);
        onehot = 4'b0001 << w;
    endfunction

    // Round-robin rule: first pending requester at or above the pointer, wrapping.
    function automatic int pick(input logic [3:0] m, input int p);
        for (int k = 0; k < 4; k++)
            if (((m >> ((p + k) % 4)) & 4'b0001) != 4'b0000) return (p + k) % 4;
        return -1;
    endfunction

    task automatic check_quiet(input string pfx);
        check({pfx, "_req_ready"},  32'(req_ready),  32'(0));
        check({pfx, "_resp_valid"}, 32'(resp_valid), 32'(0));
        check({pfx, "_resp_dist"},  resp_dist,       32'(0));
        check({pfx, "_resp_err"},   32'(resp_err),   32'(0));
        check({pfx, "_eng_start"},  32'(eng_start),  32'(0));
        check({pfx, "_eng_abort"},  32'(eng_abort),  32'(0));
        check({pfx, "_eng_src"},    32'(eng_src),    32'(0));
        check({pfx, "_eng_dest"},   32'(eng_dest),   32'(0));
        check({pfx, "_cfg_grant"},  32'(cfg_grant),  32'(0));
    endtask

    task automatic do_reset();
        reset = 1'b1; req_valid = '0; req_src = '0; req_dest = '0;
        eng_done = 1'b0; eng_dist = '0; cfg_req = 1'b0;
        tick();
        tick();
        #1 check_quiet("in_reset");
        reset = 1'b0;
        exp_ptr = 0;
        tick();
        #1 check_quiet("post_reset");
        tick();
    endtask

    // One query from IDLE to the cycle after its response. delay < 0 or
    // beyond the timeout window means the engine never answers.
    task automatic run_query(input logic [3:0] mask, input logic [19:0] srcs,
                             input logic [19:0] dsts, input int delay,
                             input logic [31:0] val, input bit hold,
                             input bit cfg_busy, input int reset_at);
        int          w;
        logic [4:0]  s, d;
        logic [31:0] edist;
        logic        eerr;
        req_valid = mask; req_src = srcs; req_dest = dsts;
        #1;
        w = pick(mask, exp_ptr);
        s = srcs[w*5 +: 5];
        d = dsts[w*5 +: 5];
        check("accept_ready", 32'(req_ready), 32'(onehot(w)));
        check("accept_no_resp", 32'(resp_valid), 32'(0));
        tick();
        if (!hold) req_valid = '0;
        #1;
        if (s == d) begin
            check("bypass_resp", 32'(resp_valid), 32'(onehot(w)));
            check("bypass_dist", resp_dist, 32'(0));
            check("bypass_err", 32'(resp_err), 32'(0));
            check("bypass_no_start", 32'(eng_start), 32'(0));
            exp_ptr = (w + 1) % 4;
            tick();
            return;
        end
        check("start_pulse", 32'(eng_start), 32'(1));
        check("start_src", 32'(eng_src), 32'(s));
        check("start_dest", 32'(eng_dest), 32'(d));
        check("start_no_ready", 32'(req_ready), 32'(0));
        tick();
        if (cfg_busy) cfg_req = 1'b1;
        edist = INF;
        eerr  = 1'b1;
        for (int k = 0; k < TIMEOUT; k++) begin
            eng_done = (k == delay);
            eng_dist = (k == delay) ? val : $urandom;
            if (k == reset_at) begin
                reset = 1'b1; req_valid = '0;
                #1;
                check("rst_no_abort", 32'(eng_abort), 32'(0));
                check("rst_no_resp", 32'(resp_valid), 32'(0));
                tick();
                reset = 1'b0; eng_done = 1'b0; cfg_req = 1'b0;
                exp_ptr = 0;
                #1 check_quiet("after_mid_reset");
                tick();
                return;
            end
            #1;
            check("busy_abort", 32'(eng_abort), 32'((k == TIMEOUT - 1) && (k != delay)));
            check("busy_no_resp", 32'(resp_valid), 32'(0));
            check("busy_no_ready", 32'(req_ready), 32'(0));
            if (cfg_busy) check("busy_cfg_held", 32'(cfg_grant), 32'(0));
            if (k == delay) begin
                edist = val;
                eerr  = (val >= INF);
                tick();
                break;
            end
            tick();
        end
        eng_done = 1'b0;
        #1;
        check("resp_valid", 32'(resp_valid), 32'(onehot(w)));
        check("resp_dist", resp_dist, edist);
        check("resp_err", 32'(resp_err), 32'(eerr));
        check("resp_eng_src", 32'(eng_src), 32'(s));
        check("resp_eng_dest", 32'(eng_dest), 32'(d));
        check("resp_no_ready", 32'(req_ready), 32'(0));
        if (cfg_busy) check("resp_cfg_held", 32'(cfg_grant), 32'(0));
        exp_ptr = (w + 1) % 4;
        tick();
    endtask

    initial begin
        logic [3:0]  m;
        logic [19:0] rs, rd;
        int          dly;
        logic [31:0] v;

        do_reset();

        // Single query: requester 1, 0 -> 3, engine answers 5 on its 10th cycle.
        run_query(4'b0010, 20'h00000, {5'd0, 5'd0, 5'd3, 5'd0}, 9, 32'd5, 0, 0, -1);

        // Fairness with all requesters held: 0,1,2,3,0.
        do_reset();
        for (int i = 0; i < 5; i++)
            run_query(4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, {5'd9, 5'd8, 5'd7, 5'd6}, 1,
                      32'(100 + i), 1, 0, -1);

        // Unreachable threshold is unsigned >= INF.
        run_query(4'b0100, 20'h00000, 20'hFFFFF, 3, INF, 0, 0, -1);
        run_query(4'b0100, 20'h00000, 20'hFFFFF, 0, INF - 32'd1, 0, 0, -1);
        run_query(4'b1000, 20'h00000, 20'hFFFFF, 2, 32'hFFFF_FFFF, 0, 0, -1);

        // src == dest bypass.
        run_query(4'b0001, {4{5'd7}}, {4{5'd7}}, 0, 32'd55, 0, 0, -1);

        // Timeout, then done landing on the final window cycle.
        run_query(4'b0010, {4{5'd1}}, {4{5'd2}}, -1, 32'd0, 0, 0, -1);
        run_query(4'b0010, {4{5'd1}}, {4{5'd2}}, TIMEOUT - 1, 32'd77, 0, 0, -1);

        // Config request arriving during BUSY waits for the response.
        run_query(4'b0001, {4{5'd3}}, {4{5'd4}}, 4, 32'd12, 0, 1, -1);
        #1;
        check("cfg_idle_no_grant", 32'(cfg_grant), 32'(0));
        check("cfg_idle_no_ready", 32'(req_ready), 32'(0));
        tick();
        #1 check("cfg_grant_rise", 32'(cfg_grant), 32'(1));
        req_valid = 4'b0001; req_src = {4{5'd5}}; req_dest = {4{5'd6}};
        eng_done = 1'b1; eng_dist = 32'd3;
        #1;
        check("cfg_blocks_ready", 32'(req_ready), 32'(0));
        check("cfg_stray_done", 32'(resp_valid), 32'(0));
        tick();
        eng_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("cfg_hold_grant", 32'(cfg_grant), 32'(1));
            check("cfg_hold_no_ready", 32'(req_ready), 32'(0));
            tick();
        end
        cfg_req = 1'b0;
        #1;
        check("cfg_drop_grant_still", 32'(cfg_grant), 32'(1));
        check("cfg_drop_no_ready", 32'(req_ready), 32'(0));
        tick();
        #1 check("cfg_grant_fall", 32'(cfg_grant), 32'(0));
        run_query(4'b0001, {4{5'd5}}, {4{5'd6}}, 2, 32'd3, 0, 0, -1);

        // Randomized traffic.
        for (int i = 0; i < 40; i++) begin
            m  = 4'($urandom_range(1, 15));
            rs = 20'($urandom);
            rd = ($urandom_range(0, 3) == 0) ? rs : 20'($urandom);
            dly = int'($urandom_range(0, 20));
            case ($urandom_range(0, 3))
                0:       v = INF;
                1:       v = INF - 32'd1;
                default: v = 32'($urandom_range(0, 100000));
            endcase
            run_query(m, rs, rd, dly, v, bit'($urandom_range(0, 1)), 0, -1);
        end

        // Reset on what would be the timeout cycle, then a fresh query.
        run_query(4'b0100, {4{5'd1}}, {4{5'd9}}, -1, 32'd0, 0, 0, TIMEOUT - 1);
        run_query(4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, {5'd8, 5'd7, 5'd6, 5'd5}, 1,
                  32'd42, 0, 0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/route_query_sched.md
Name: route_query_sched

Overview:
- Scheduler in front of the single shortest-path engine (32-node graph, 32-bit distances).
- Accepts route queries (src, dest) from NREQ requesters and arbitrates between them round-robin.
- Sequences the engine through a start/done handshake and returns the distance to the winning requester.
- Gates graph-configuration writes so they happen only while the engine is idle.

Parameters:
- NREQ, 4, number of query requesters.
- NODE_W, 5, node index width (32 nodes).
- DIST_W, 32, distance width.
- INF, 9999999, engine's "unreachable" distance value.
- TIMEOUT, 4096, max engine cycles per query before abort.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- req_valid  in  NREQ  per-requester query pending.
- req_src  in  NREQ*NODE_W  packed source nodes; requester k occupies bits [k*NODE_W +: NODE_W].
- req_dest  in  NREQ*NODE_W  packed destination nodes, same packing.
- req_ready  out  NREQ  one-hot, 1-cycle accept pulse.
- resp_valid  out  NREQ  one-hot, 1-cycle response pulse.
- resp_dist  out  DIST_W  distance; valid with resp_valid.
- resp_err  out  1  unreachable or timeout; valid with resp_valid.
- eng_start  out  1  1-cycle engine start pulse.
- eng_abort  out  1  1-cycle engine abort pulse.
- eng_src  out  NODE_W  engine source node, held through the query.
- eng_dest  out  NODE_W  engine destination node, held through the query.
- eng_done  in  1  engine result ready (1-cycle pulse).
- eng_dist  in  DIST_W  engine result; sampled on eng_done.
- cfg_req  in  1  graph-write agent requests the engine.
- cfg_grant  out  1  graph writes permitted.

Behaviour:
- Clocking and reset: one clock. reset is synchronous and active-high.
- Reset values:
  - All outputs 0.
  - State IDLE; rr pointer 0 (requester 0 has top priority first).
  - Timeout counter 0.
- FSM states: IDLE, CFG, START, BUSY, RESP.
- IDLE:
  - cfg_req=1 has priority over queries: go to CFG.
  - Otherwise, if any req_valid, grant the first set bit searching from rr pointer upward with wrap. Pulse req_ready[g] that cycle. Latch g, src and dest.
  - If src==dest: go to RESP with dist 0, err 0. The engine is not started.
  - Otherwise go to START.
- CFG:
  - cfg_grant=1 for as long as cfg_req=1.
  - Registered: grant rises the cycle after entry and falls the cycle after cfg_req drops.
  - Return to IDLE when cfg_req drops. No queries are accepted while in CFG.
- START: eng_start=1 for one cycle; eng_src/eng_dest are stable from this cycle until RESP. Clear the counter. Go to BUSY.
- BUSY:
  - Counter increments each cycle.
  - On eng_done: latch eng_dist and set err = (eng_dist >= INF). Go to RESP.
  - If the counter reaches TIMEOUT-1 without eng_done: pulse eng_abort, set err=1, dist=INF. Go to RESP.
  - eng_done together with the timeout cycle: done wins, no abort.
- RESP:
  - resp_valid[g]=1 for one cycle with resp_dist/resp_err.
  - rr pointer becomes (g+1) mod NREQ. Go to IDLE.
- Latency:
  - Accept to response = 3 + engine cycles (accept, START, BUSY≥1, RESP).
  - src==dest response is on the cycle after accept.
- Request handling:
  - Requesters hold req_valid/src/dest until they see req_ready.
  - Dropping req_valid before the grant withdraws the request; no error.
  - req_valid stays asserted after accept: it is a new query, eligible from the next IDLE.
- Stray inputs:
  - eng_done in IDLE, CFG, START or RESP is ignored.
  - cfg_req arriving during a query waits until IDLE.
- Back-to-back: at most one query is in flight; a new grant can occur in the cycle after RESP.
- Reset mid-query: FSM returns to IDLE, no response and no abort pulse; the engine is reset by the same reset.
- Arithmetic: counter width is clog2(TIMEOUT); the comparison with INF is unsigned.

Decomposition:
- Package route_pkg holds:
  - NODE_W, DIST_W and INF constants.
  - The FSM state enum (IDLE, CFG, START, BUSY, RESP).
  - A query struct (src, dest).
- One sub-module, rr_arbiter: NREQ-wide combinational round-robin grant from a req vector and a pointer, with one-hot grant and index outputs.

Test Plan:
- Single query: req_valid[1], src=0, dest=3, engine returns 5 after 10 cycles → req_ready=0010, eng_start one cycle later with eng_src=0/eng_dest=3, then resp_valid=0010, resp_dist=5, resp_err=0.
- Fairness: all four req_valid held high, engine done after 2 cycles → grants in order 0,1,2,3,0; no requester is granted twice before the others.
- Unreachable and bypass:
  - Engine returns 9999999 → resp_err=1, resp_dist=9999999.
  - src=dest=7 → response dist 0 the cycle after accept, eng_start never pulses.
- Timeout: TIMEOUT=16, engine never done → eng_abort pulses 15 cycles after BUSY entry, then resp_err=1 and dist=INF. Repeat with eng_done on the final cycle → no abort, normal response.
- Config gating:
  - cfg_req raised during BUSY → cfg_grant stays 0 until the response, then rises.
  - req_valid asserted during CFG → no req_ready until cfg_req drops.
- Reset mid-BUSY → all outputs 0 the next cycle, no resp_valid; a fresh query afterwards is granted to requester 0 first.
